// File: rtl/bit_reverse_reorder.sv
`timescale 1ns/1ps
// Ping-pong frame buffer: natural-order samples in, each frame out in bit-reversed order.
// One bank fills while the other drains through a prefetch stage and a registered output stage.
module bit_reverse_reorder #(
    parameter int DATA_WIDTH = 32,
    parameter int FFT_SIZE   = 16
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  wrValidIn,
    output logic                  wrConsentOut,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    output logic                  rdValidOut,
    input  logic                  rdConsentIn,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic                  rdLastOut
);
    localparam int ADDR_WIDTH = $clog2(FFT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FFT_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] rev;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev[ADDR_WIDTH-1-i] = addr[i];
        end
        return rev;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [0:2*FFT_SIZE-1];

    logic [ADDR_WIDTH-1:0] wr_cnt_r;
    logic                  wr_bank_r;
    logic                  wr_consent_r;
    logic [1:0]            bank_full_r;

    logic [ADDR_WIDTH-1:0] rd_cnt_r;
    logic                  rd_bank_r;
    logic                  pre_valid_r;
    logic [DATA_WIDTH-1:0] pre_data_r;
    logic                  pre_last_r;

    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_last_r;
    logic                  out_bank_r;

    logic                  wr_xfer_s;
    logic                  wr_done_s;
    logic                  rd_xfer_s;
    logic                  rd_done_s;
    logic                  out_ready_s;
    logic                  pre_ready_s;
    logic                  issue_s;
    logic                  issue_done_s;
    logic [1:0]            set_s;
    logic [1:0]            clr_s;
    logic [1:0]            bank_full_nxt_s;
    logic                  wr_bank_nxt_s;

    assign wr_xfer_s    = wrValidIn & wr_consent_r;
    assign wr_done_s    = wr_xfer_s & (wr_cnt_r == LAST_ADDR);
    assign rd_xfer_s    = out_valid_r & rdConsentIn;
    assign rd_done_s    = rd_xfer_s & out_last_r;
    assign out_ready_s  = ~out_valid_r | rdConsentIn;
    assign pre_ready_s  = ~pre_valid_r | out_ready_s;
    // Reads run ahead of the output; the drained bank is only released on its last transfer.
    assign issue_s      = bank_full_r[rd_bank_r] & pre_ready_s;
    assign issue_done_s = issue_s & (rd_cnt_r == LAST_ADDR);

    assign set_s           = {wr_done_s & wr_bank_r, wr_done_s & ~wr_bank_r};
    assign clr_s           = {rd_done_s & out_bank_r, rd_done_s & ~out_bank_r};
    assign bank_full_nxt_s = (bank_full_r & ~clr_s) | set_s;
    assign wr_bank_nxt_s   = wr_bank_r ^ wr_done_s;

    assign wrConsentOut = wr_consent_r;
    assign rdValidOut   = out_valid_r;
    assign rdDataOut    = out_data_r;
    assign rdLastOut    = out_last_r;

    // Write counter, write bank pointer and registered write consent.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            wr_cnt_r     <= '0;
            wr_bank_r    <= 1'b0;
            wr_consent_r <= 1'b0;
        end else begin
            if (wr_xfer_s) begin
                wr_cnt_r <= wr_cnt_r + ONE_ADDR;
            end
            wr_bank_r    <= wr_bank_nxt_s;
            wr_consent_r <= ~bank_full_nxt_s[wr_bank_nxt_s];
        end
    end

    // Bank occupancy flags; a set and a clear in the same cycle always hit different banks.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            bank_full_r <= 2'b00;
        end else begin
            bank_full_r <= bank_full_nxt_s;
        end
    end

    // Sample storage, both banks side by side; contents need no reset.
    always_ff @(posedge clkIn) begin
        if (wr_xfer_s) begin
            mem_r[{wr_bank_r, wr_cnt_r}] <= wrDataIn;
        end
    end

    // Prefetch stage: bit-reversed RAM read and read address counter.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            rd_cnt_r    <= '0;
            rd_bank_r   <= 1'b0;
            pre_valid_r <= 1'b0;
            pre_data_r  <= '0;
            pre_last_r  <= 1'b0;
        end else if (pre_ready_s) begin
            pre_valid_r <= issue_s;
            if (issue_s) begin
                pre_data_r <= mem_r[{rd_bank_r, bit_rev(rd_cnt_r)}];
                pre_last_r <= (rd_cnt_r == LAST_ADDR);
                rd_cnt_r   <= rd_cnt_r + ONE_ADDR;
                if (issue_done_s) begin
                    rd_bank_r <= ~rd_bank_r;
                end
            end
        end
    end

    // Output stage: holds data and last flag steady while the consumer stalls.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_bank_r  <= 1'b0;
        end else begin
            if (out_ready_s) begin
                out_valid_r <= pre_valid_r;
                out_last_r  <= pre_valid_r & pre_last_r;
                if (pre_valid_r) begin
                    out_data_r <= pre_data_r;
                end
            end
            if (rd_done_s) begin
                out_bank_r <= ~out_bank_r;
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
`timescale 1ns/1ps
// Directed bench: an FFT_SIZE=8 and an FFT_SIZE=4 instance share stimulus, one is observed at a time.
// A negedge monitor compares every presented sample against a hand-built expected order.
module tb_bit_reverse_reorder;
    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        wr_valid   = 1'b0;
    logic [31:0] wr_data    = 32'd0;
    logic        rd_consent = 1'b0;
    logic        sel4       = 1'b0;

    logic        wr_consent8, rd_valid8, rd_last8;
    logic        wr_consent4, rd_valid4, rd_last4;
    logic [31:0] rd_data8, rd_data4;

    logic        wr_consent_s, rd_valid_s, rd_last_s;
    logic [31:0] rd_data_s;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_acc   = 0;
    int          rx_cnt   = 0;
    int          rx0;
    logic        writer_done;
    logic        prev_xfer_nonlast = 1'b0;
    logic [32:0] exp_q [$];

    logic [31:0] ord8 [8] = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    logic [31:0] ord4 [4] = '{32'd0, 32'd2, 32'd1, 32'd3};

    assign wr_consent_s = sel4 ? wr_consent4 : wr_consent8;
    assign rd_valid_s   = sel4 ? rd_valid4   : rd_valid8;
    assign rd_last_s    = sel4 ? rd_last4    : rd_last8;
    assign rd_data_s    = sel4 ? rd_data4    : rd_data8;

    bit_reverse_reorder #(.DATA_WIDTH(32), .FFT_SIZE(8)) dut8 (
        .clkIn(clk), .rstIn(rst),
        .wrValidIn(wr_valid), .wrConsentOut(wr_consent8), .wrDataIn(wr_data),
        .rdValidOut(rd_valid8), .rdConsentIn(rd_consent), .rdDataOut(rd_data8), .rdLastOut(rd_last8)
    );

    bit_reverse_reorder #(.DATA_WIDTH(32), .FFT_SIZE(4)) dut4 (
        .clkIn(clk), .rstIn(rst),
        .wrValidIn(wr_valid), .wrConsentOut(wr_consent4), .wrDataIn(wr_data),
        .rdValidOut(rd_valid4), .rdConsentIn(rd_consent), .rdDataOut(rd_data4), .rdLastOut(rd_last4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_frame(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] off;
            if (n == 8) off = ord8[k[2:0]];
            else        off = ord4[k[1:0]];
            exp_q.push_back({(k == n - 1), base + off});
        end
    endtask

    task automatic push(input logic [31:0] val);
        logic acc;
        int   waits;
        acc      = 1'b0;
        waits    = 0;
        wr_valid = 1'b1;
        wr_data  = val;
        while (!acc && waits < 300) begin
            acc = wr_consent_s;
            @(posedge clk);
            #1;
            waits++;
        end
        check_eq("push_accepted", 32'(acc), 32'd1);
        if (acc) wr_acc++;
    endtask

    task automatic write_frame(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) push(base + 32'(k));
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, 32'(rd_valid_s), 32'd0);
    endtask

    task automatic do_reset(input logic use4);
        @(posedge clk);
        #3;
        rst      = 1'b1;
        sel4     = use4;
        wr_valid = 1'b0;
        #1;
        check_eq("rst_wr_consent", 32'(wr_consent_s), 32'd0);
        check_eq("rst_rd_valid",   32'(rd_valid_s),   32'd0);
        check_eq("rst_rd_last",    32'(rd_last_s),    32'd0);
        check_eq("rst_rd_data",    rd_data_s,         32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("release_consent_low", 32'(wr_consent_s), 32'd0);
        @(posedge clk);
        #1;
        check_eq("release_consent_high", 32'(wr_consent_s), 32'd1);
    endtask

    // Monitor: every presented sample must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_xfer_nonlast = 1'b0;
        end else begin
            if (prev_xfer_nonlast) check_eq("no_intra_frame_gap", 32'(rd_valid_s), 32'd1);
            if (rd_valid_s) begin
                check_eq("sample_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("rd_data", rd_data_s, exp_q[0][31:0]);
                    check_eq("rd_last", 32'(rd_last_s), 32'(exp_q[0][32]));
                    if (rd_consent) begin
                        void'(exp_q.pop_front());
                        rx_cnt++;
                    end
                end
                prev_xfer_nonlast = rd_consent & ~rd_last_s;
            end else begin
                prev_xfer_nonlast = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // single frame, latency of two edges after the completing write
        rd_consent = 1'b1;
        exp_frame(32'd0, 8);
        write_frame(32'd0, 8);
        check_eq("lat_edge0", 32'(rd_valid_s), 32'd0);
        @(posedge clk); #1;
        check_eq("lat_edge1", 32'(rd_valid_s), 32'd0);
        @(posedge clk); #1;
        check_eq("lat_edge2", 32'(rd_valid_s), 32'd1);
        check_eq("lat_first_data", rd_data_s, 32'd0);
        drain("single_frame");

        // four frames streamed continuously
        for (int f = 0; f < 4; f++) exp_frame(32'(8 * f), 8);
        for (int k = 0; k < 32; k++) push(32'(k));
        wr_valid = 1'b0;
        drain("stream4");

        // consumer stalled: two frames fit, third waits for a freed bank
        rd_consent = 1'b0;
        wr_acc     = 0;
        exp_frame(32'd40, 8);
        exp_frame(32'd48, 8);
        exp_frame(32'd56, 8);
        fork
            begin
                for (int k = 0; k < 24; k++) push(32'(40 + k));
                wr_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 200 && wr_acc < 16; i++) @(posedge clk);
                repeat (5) @(posedge clk);
                #1;
                check_eq("stall_two_frames", 32'(wr_acc), 32'd16);
                check_eq("stall_consent_low", 32'(wr_consent_s), 32'd0);
                rd_consent = 1'b1;
                repeat (7) @(posedge clk);
                #1;
                check_eq("consent_before_free", 32'(wr_consent_s), 32'd0);
                @(posedge clk);
                #1;
                check_eq("consent_after_free", 32'(wr_consent_s), 32'd1);
                check_eq("next_bank_no_bubble", 32'(rd_valid_s), 32'd1);
                rd_consent = 1'b0;
                repeat (12) @(posedge clk);
                #1;
                rd_consent = 1'b1;
            end
        join
        drain("stall3");

        // random consumer stalls
        exp_frame(32'd100, 8);
        exp_frame(32'd108, 8);
        writer_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) push(32'(100 + k));
                wr_valid    = 1'b0;
                writer_done = 1'b1;
            end
            begin
                for (int i = 0; i < 2000 && (!writer_done || exp_q.size() > 0); i++) begin
                    rd_consent = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                rd_consent = 1'b1;
            end
        join
        drain("random_stall");

        // reset after five writes, then reset in the middle of a read
        for (int k = 0; k < 5; k++) push(32'(200 + k));
        wr_valid = 1'b0;
        do_reset(1'b0);
        exp_frame(32'd300, 8);
        write_frame(32'd300, 8);
        rx0 = rx_cnt;
        for (int i = 0; i < 100 && rx_cnt < rx0 + 3; i++) @(posedge clk);
        do_reset(1'b0);
        exp_frame(32'd10, 8);
        write_frame(32'd10, 8);
        drain("after_reset");

        // FFT_SIZE=4: frame completes on the same edge the other bank is freed
        do_reset(1'b1);
        rd_consent = 1'b1;
        exp_frame(32'd0, 4);
        exp_frame(32'd4, 4);
        exp_frame(32'd8, 4);
        for (int k = 0; k < 4; k++) push(32'(k));
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) push(32'(4 + k));
        check_eq("coincident_consent", 32'(wr_consent_s), 32'd1);
        for (int k = 0; k < 4; k++) push(32'(8 + k));
        wr_valid = 1'b0;
        drain("fft4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_reverse_reorder.md
Name: bit_reverse_reorder

Overview:
- Ping-pong frame buffer that accepts FFT samples in natural order and emits each frame in bit-reversed address order.
- Sits directly downstream of the input FIFO. It consumes the FIFO's read port through the valid/consent handshake and feeds the first butterfly stage.
- Two banks of FFT_SIZE words: one bank fills while the other drains, so frames stream continuously without bubbles.

Parameters:
- DATA_WIDTH, 32, width of one sample word (complex sample packed by the caller).
- FFT_SIZE, 16, frame length in samples. Must be a power of two, >= 4.
- ADDR_WIDTH (localparam), $clog2(FFT_SIZE).

Ports:
- clkIn  input  1  clock, all state on rising edge.
- rstIn  input  1  reset. Asynchronous, active-high.
- wrValidIn  input  1  upstream sample valid.
- wrConsentOut  output  1  block can accept a sample this cycle.
- wrDataIn  input  DATA_WIDTH  upstream sample.
- rdValidOut  output  1  rdDataOut holds a valid sample.
- rdConsentIn  input  1  downstream accepts the sample this cycle.
- rdDataOut  output  DATA_WIDTH  reordered sample.
- rdLastOut  output  1  qualifies rdDataOut as the final sample of a frame.

Behaviour:
- Transfer rules:
  - Write transfer: wrValidIn & wrConsentOut at a rising edge.
  - Read transfer: rdValidOut & rdConsentIn at a rising edge.
- Reset (asynchronous, any time, including mid-frame):
  - wrConsentOut=0, rdValidOut=0, rdLastOut=0, rdDataOut=0.
  - Both banks marked empty; write counter, read counter and bank pointers = 0.
  - Partial frames are discarded.
  - wrConsentOut rises on the first rising edge after rstIn deasserts.
- Write side:
  - Counter wrCnt[ADDR_WIDTH-1:0] addresses bank wrBank, natural order.
  - Each write transfer stores wrDataIn at wrCnt and increments wrCnt.
  - On the write with wrCnt==FFT_SIZE-1: wrCnt wraps to 0, bankFull[wrBank] set, wrBank toggles.
  - wrConsentOut = registered !bankFull of the next write bank. It deasserts in the cycle after the last write if the other bank is still full.
  - Data on wrDataIn while wrConsentOut=0 is ignored; no RAM write occurs.
- Read side:
  - Counter rdCnt addresses bank rdBank at bitrev(rdCnt), where bit i maps to bit ADDR_WIDTH-1-i.
  - RAM read latency is 1 cycle; output is registered.
  - Latency: the frame-completing write at edge t gives rdValidOut=1 after edge t+2, carrying sample index 0.
  - With rdConsentIn held high: one sample per cycle, no bubbles inside a frame.
  - No bubble between frames if the next bank is already full.
  - Backpressure: while rdValidOut & !rdConsentIn, rdDataOut and rdLastOut hold stable and the read address does not advance. A one-entry skid/prefetch register is permitted internally.
  - rdLastOut=1 exactly with the sample at rdCnt==FFT_SIZE-1.
  - On the read transfer of that sample: bankFull[rdBank] cleared, rdBank toggles, rdCnt wraps to 0.
  - rdValidOut drops after the last sample if the other bank is not full.
- Simultaneous events:
  - A frame completing on the write side in the same cycle a bank is freed on the read side: both flags update and both take effect.
  - wrConsentOut re-asserts the cycle after the freeing read transfer.
  - A bank is never written while it is full. A bank is never read while it is not full.
- Full/empty:
  - Both banks full: wrConsentOut=0.
  - Both banks empty: rdValidOut=0.
  - Maximum storage is 2*FFT_SIZE samples.

Test Plan:
- Single frame, FFT_SIZE=8, write 0..7 back-to-back, rdConsentIn=1 -> output 0,4,2,6,1,5,3,7. rdLastOut only with 7. First rdValidOut two edges after the 8th write.
- Continuous stream of 4 frames (values 0..31), both sides always ready -> no wrConsentOut drop, no rdValidOut gap after the first frame, every frame bit-reversed.
- rdConsentIn=0 with three frames offered -> two frames accepted (16 writes), then wrConsentOut=0. Raising rdConsentIn for 8 transfers re-asserts wrConsentOut the next cycle.
- Random rdConsentIn toggling (50%) -> rdDataOut/rdLastOut stable during stalls; output sequence identical to the unstalled case.
- Assert rstIn asynchronously mid-frame (after 5 writes, and again mid-read) -> outputs 0 immediately. A new frame 10..17 afterwards yields 10,14,12,16,11,15,13,17 with no stale data.
- FFT_SIZE=4 boundary, write 0..3 -> output 0,2,1,3. Same-cycle frame-complete and bank-free edge shows no lost or duplicated frame.
